// File: rtl/vram_dma_pkg.sv
// Shared definitions for the OAM/VRAM block-copy engine: FSM states,
// transfer length and the trigger register address used by the decoder.
package vram_dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HALT,
    READ,
    WRITE
  } dma_state_t;

  localparam int DMA_LENGTH = 256;
  localparam logic [15:0] DMA_TRIGGER_ADDR = 16'h4014;

endpackage

// File: rtl/vram_dma.sv
// Page-to-VRAM copy engine: halts the 65C02 via RDY, then alternates
// READ/WRITE bus cycles to move 2^LENGTH_LOG2 bytes from $PP00 to DEST_BASE.
module vram_dma
  import vram_dma_pkg::*;
#(
  parameter logic [15:0] DEST_BASE   = 16'h3F00,
  parameter int          LENGTH_LOG2 = 8
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic        cpu_clk_enable,
  input  logic        SELECT_dma,
  input  logic        write_enable,
  input  logic [7:0]  data_in,
  output logic        cpu_rdy,
  output logic        dma_bus_enable,
  output logic [15:0] dma_address,
  output logic        dma_read_enable,
  output logic        dma_write_enable,
  output logic [7:0]  dma_data_out,
  output logic        dma_busy
);

  dma_state_t state, state_next;
  logic [LENGTH_LOG2-1:0] count;
  logic [7:0] src_page;
  logic [7:0] data_latch;
  logic trigger;
  logic last_byte;

  assign trigger   = SELECT_dma && write_enable;
  assign last_byte = (count == {LENGTH_LOG2{1'b1}});

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      src_page   <= 8'h00;
      data_latch <= 8'h00;
    end else if (cpu_clk_enable) begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (trigger) begin
            src_page <= data_in;
            count    <= '0;
          end
        end
        READ:    data_latch <= data_in;
        WRITE:   count <= count + LENGTH_LOG2'(1);
        default: ;
      endcase
    end
  end

  // Outputs depend only on registered state so the bus sees stable values all cycle.
  always_comb begin
    state_next       = state;
    cpu_rdy          = 1'b1;
    dma_bus_enable   = 1'b0;
    dma_address      = 16'h0000;
    dma_read_enable  = 1'b0;
    dma_write_enable = 1'b0;
    dma_data_out     = 8'h00;
    case (state)
      IDLE: begin
        if (trigger) state_next = HALT;
      end
      HALT: begin
        cpu_rdy = 1'b0;
        if (!write_enable) state_next = READ;
      end
      READ: begin
        cpu_rdy         = 1'b0;
        dma_bus_enable  = 1'b1;
        dma_read_enable = 1'b1;
        dma_address     = {src_page, 8'(count)};
        state_next      = WRITE;
      end
      WRITE: begin
        cpu_rdy          = 1'b0;
        dma_bus_enable   = 1'b1;
        dma_write_enable = 1'b1;
        dma_address      = DEST_BASE + 16'(count);
        dma_data_out     = data_latch;
        state_next       = last_byte ? IDLE : READ;
      end
      default: state_next = IDLE;
    endcase
    dma_busy = (state != IDLE);
  end

endmodule
